spi_word_tx: RTL

SPI_WORD_TX -- requirements
Module: spi_word_tx

---
 rtl/ctrl_spi_pkg.sv | 26 ++
 rtl/spi_tx_tick.sv | 38 +++
 rtl/spi_word_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_spi_pkg.sv
// Shared constants and state encoding for the SPI word transmitter.
// SPI_TX_CHECKSUM_EN selects the 80-bit frame (four words plus a sum word).
package ctrl_spi_pkg;

    localparam int WORD_BITS        = 16;
    localparam int N_WORDS          = 4;
    localparam int FRAME_BITS_PLAIN = WORD_BITS * N_WORDS;
    localparam int FRAME_BITS_CSUM  = WORD_BITS * (N_WORDS + 1);

`ifdef SPI_TX_CHECKSUM_EN
    localparam int FRAME_BITS = FRAME_BITS_CSUM;
`else
    localparam int FRAME_BITS = FRAME_BITS_PLAIN;
`endif

    // Wide enough to hold FRAME_BITS itself, since the bit counter starts there.
    localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/spi_tx_tick.sv
// Half-period timer: strobes on the last cycle of every SPI phase while enabled.
// Parked at its reload value whenever the transmitter is not busy.
module spi_tx_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic strobe
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!en) begin
            cnt_next = RELOAD;
        end else if (cnt_reg == 8'd0) begin
            cnt_next = RELOAD;
        end else begin
            cnt_next = cnt_reg - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 8'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign strobe = en && (cnt_reg == 8'd0);

endmodule

// File: rtl/spi_word_tx.sv
// Mode-0 SPI transmitter sending four 16-bit words MSB first under one chip select.
// Defining SPI_TX_CHECKSUM_EN appends a fifth word holding the 16-bit sum of the four.
module spi_word_tx
    import ctrl_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [WORD_BITS-1:0] i_data0,
    input  logic [WORD_BITS-1:0] i_data1,
    input  logic [WORD_BITS-1:0] i_data2,
    input  logic [WORD_BITS-1:0] i_data3,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_SPI_CS,
    output logic                 o_SPI_clock,
    output logic                 o_SPI_data
);

    state_t                 state_reg;
    state_t                 state_next;
    logic [FRAME_BITS-1:0]  shreg_reg;
    logic [FRAME_BITS-1:0]  shreg_next;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt_next;
    logic                   sck_reg;
    logic                   sck_next;
    logic                   cs_reg;
    logic                   cs_next;
    logic                   busy_reg;
    logic                   busy_next;
    logic                   done_reg;
    logic                   done_next;

    logic                   strobe;
    logic [WORD_BITS-1:0]   words [N_WORDS];
    logic [FRAME_BITS-1:0]  frame_load;

    assign words[0] = i_data0;
    assign words[1] = i_data1;
    assign words[2] = i_data2;
    assign words[3] = i_data3;

    // Word 0 lands in the most significant slot so it leaves first.
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_pack
        assign frame_load[FRAME_BITS-1-gi*WORD_BITS -: WORD_BITS] = words[gi];
    end

`ifdef SPI_TX_CHECKSUM_EN
    logic [WORD_BITS-1:0] csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            csum = csum + words[i];
        end
    end

    assign frame_load[WORD_BITS-1:0] = csum;
`endif

    spi_tx_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (i_clock),
        .rst_n  (i_reset_n),
        .en     (busy_reg),
        .strobe (strobe)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= ST_IDLE;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            sck_reg     <= 1'b0;
            cs_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
            sck_reg     <= sck_next;
            cs_reg      <= cs_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        bit_cnt_next = bit_cnt_reg;
        sck_next     = sck_reg;
        cs_next      = cs_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    shreg_next   = frame_load;
                    bit_cnt_next = BIT_CNT_W'(FRAME_BITS);
                    sck_next     = 1'b0;
                    cs_next      = 1'b0;
                    busy_next    = 1'b1;
                    state_next   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (strobe) begin
                    sck_next   = 1'b1;
                    state_next = ST_SHIFT;
                end
            end

            // Data moves on the falling edge so it is stable across each rising edge.
            ST_SHIFT: begin
                if (strobe) begin
                    if (sck_reg) begin
                        sck_next   = 1'b0;
                        shreg_next = {shreg_reg[FRAME_BITS-2:0], 1'b0};
                        if (bit_cnt_reg != '0) begin
                            bit_cnt_next = bit_cnt_reg - BIT_CNT_W'(1);
                        end
                    end else if (bit_cnt_reg == '0) begin
                        cs_next    = 1'b1;
                        done_next  = 1'b1;
                        state_next = ST_GAP;
                    end else begin
                        sck_next = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (strobe) begin
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                sck_next   = 1'b0;
                cs_next    = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_busy      = busy_reg;
    assign o_done      = done_reg;
    assign o_SPI_CS    = cs_reg;
    assign o_SPI_clock = sck_reg;
    assign o_SPI_data  = shreg_reg[FRAME_BITS-1];

endmodule
